// File: rtl/intr_ctrl8_if.sv
// Interrupt controller request/grant bundle: host-side requests, mask writes and ack/eoi in,
// registered grant state out.
interface intr_ctrl8_if;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_d;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] vec;
    logic       busy;
    logic [7:0] pend;

    modport slave  (input  req, mask_we, mask_d, ack, eoi,
                    output irq, vec, busy, pend);
    modport master (output req, mask_we, mask_d, ack, eoi,
                    input  irq, vec, busy, pend);
endinterface

// File: rtl/intr_ctrl8.sv
// 8-channel edge-triggered interrupt controller, fixed or rotating priority, one grant at a time.
// req edge -> pend after 1 clk -> irq after 2 clks; host paces service with ack/eoi, extra edges stay pending.
module intr_ctrl8 #(
    parameter bit ROTATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    intr_ctrl8_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t     r_state;
    logic [7:0] r_req_q;
    logic [7:0] r_pend;
    logic [7:0] r_mask;
    logic       r_irq;
    logic [2:0] r_vec;
    logic       r_busy;
    logic [2:0] r_lp;

    state_t     w_state_nxt;
    logic       w_irq_nxt;
    logic [2:0] w_vec_nxt;
    logic       w_busy_nxt;
    logic [2:0] w_lp_nxt;
    logic [7:0] w_clr;
    logic [7:0] w_edge;
    logic [7:0] w_elig;
    logic [2:0] w_lp_eff;
    logic [2:0] w_win;
    logic       w_found;
    logic       w_abort;

    assign w_edge   = bus.req & ~r_req_q;
    assign w_elig   = r_pend & ~r_mask;
    // With lp held at 0 the rotating search order degenerates to 7..0, so one arbiter serves both modes.
    assign w_lp_eff = ROTATE ? r_lp : 3'd0;
    assign w_abort  = bus.mask_we & bus.mask_d[r_vec];

    always_comb begin
        logic [2:0] ch;
        ch      = 3'd0;
        w_win   = 3'd0;
        w_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ch = w_lp_eff - 3'd1 - 3'(i);
            if (!w_found && w_elig[ch]) begin
                w_win   = ch;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_irq;
        w_vec_nxt   = r_vec;
        w_busy_nxt  = r_busy;
        w_lp_nxt    = r_lp;
        w_clr       = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_irq_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt = S_REQ;
                    w_vec_nxt   = w_win;
                    w_irq_nxt   = 1'b1;
                end
            end
            S_REQ: begin
                w_irq_nxt = 1'b1;
                // Masking the granted channel withdraws the grant even if ack arrives together.
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_irq_nxt   = 1'b0;
                end else if (bus.ack) begin
                    w_state_nxt = S_SERVICE;
                    w_irq_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_clr       = 8'h01 << r_vec;
                end
            end
            S_SERVICE: begin
                w_busy_nxt = 1'b1;
                if (bus.eoi) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    if (ROTATE) w_lp_nxt = r_vec;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_irq_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req_q <= 8'h00;
            r_pend  <= 8'h00;
            r_mask  <= 8'h00;
            r_irq   <= 1'b0;
            r_vec   <= 3'd0;
            r_busy  <= 1'b0;
            r_lp    <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_req_q <= bus.req;
            // A new edge on the channel being acked wins over the clear.
            r_pend  <= (r_pend & ~w_clr) | w_edge;
            if (bus.mask_we) r_mask <= bus.mask_d;
            r_irq   <= w_irq_nxt;
            r_vec   <= w_vec_nxt;
            r_busy  <= w_busy_nxt;
            r_lp    <= w_lp_nxt;
        end
    end

    assign bus.irq  = r_irq;
    assign bus.vec  = r_vec;
    assign bus.busy = r_busy;
    assign bus.pend = r_pend;
endmodule

// File: tb/tb_intr_ctrl8.sv
// Bench for intr_ctrl8: fixed-priority and rotating instances share stimulus; expectations queued per step.
module tb_intr_ctrl8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       mask_we = 1'b0;
    logic [7:0] mask_d = 8'h00;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    intr_ctrl8_if if0 ();
    intr_ctrl8_if if1 ();

    assign if0.req = req;  assign if0.mask_we = mask_we;  assign if0.mask_d = mask_d;
    assign if0.ack = ack;  assign if0.eoi = eoi;
    assign if1.req = req;  assign if1.mask_we = mask_we;  assign if1.mask_d = mask_d;
    assign if1.ack = ack;  assign if1.eoi = eoi;

    intr_ctrl8 #(.ROTATE(1'b0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(if0));
    intr_ctrl8 #(.ROTATE(1'b1)) u_rot (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [7:0] req;
        logic       mwe;
        logic [7:0] md;
        logic       ack;
        logic       eoi;
        logic       irq;
        logic [2:0] vec;
        logic       busy;
        logic [7:0] pend;
    } vec_t;

    typedef struct {
        logic [12:0] exp;
        bit          dut;
        string       name;
    } sb_t;

    vec_t tbl[24];
    sb_t  sbq[$];

    function automatic logic [12:0] outs(input bit d);
        if (d) return {if1.irq, if1.vec, if1.busy, if1.pend};
        return {if0.irq, if0.vec, if0.busy, if0.pend};
    endfunction

    task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got irq=%0b vec=%0d busy=%0b pend=%02h, want irq=%0b vec=%0d busy=%0b pend=%02h",
                     nm, got[12], got[11:9], got[8], got[7:0], exp[12], exp[11:9], exp[8], exp[7:0]);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, queue the expectation, compare after the rising edge.
    task automatic step(input logic [7:0] r, input logic mwe, input logic [7:0] md, input logic a,
                        input logic e, input bit d, input logic xi, input logic [2:0] xv,
                        input logic xb, input logic [7:0] xp, input string nm);
        sb_t ent;
        @(negedge clk);
        req = r; mask_we = mwe; mask_d = md; ack = a; eoi = e;
        sbq.push_back('{exp: {xi, xv, xb, xp}, dut: d, name: nm});
        @(posedge clk);
        #1;
        ent = sbq.pop_front();
        chk(ent.name, outs(ent.dut), ent.exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 8'h00; mask_we = 1'b0; mask_d = 8'h00; ack = 1'b0; eoi = 1'b0;
        #1;
        chk("reset_fix", outs(1'b0), 13'h0);
        chk("reset_rot", outs(1'b1), 13'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //          req   mwe md    ack eoi   irq vec  busy pend
        tbl[0]  = '{8'h00, 0, 8'h00, 0, 0,   0, 3'd0, 0, 8'h00};
        tbl[1]  = '{8'h24, 0, 8'h00, 0, 0,   0, 3'd0, 0, 8'h24};
        tbl[2]  = '{8'h24, 0, 8'h00, 0, 0,   1, 3'd5, 0, 8'h24};
        tbl[3]  = '{8'h24, 0, 8'h00, 0, 0,   1, 3'd5, 0, 8'h24};
        tbl[4]  = '{8'h00, 0, 8'h00, 1, 0,   0, 3'd5, 1, 8'h04};
        tbl[5]  = '{8'h00, 0, 8'h00, 1, 0,   0, 3'd5, 1, 8'h04};
        tbl[6]  = '{8'h00, 0, 8'h00, 0, 1,   0, 3'd5, 0, 8'h04};
        tbl[7]  = '{8'h00, 0, 8'h00, 0, 0,   1, 3'd2, 0, 8'h04};
        tbl[8]  = '{8'h80, 0, 8'h00, 0, 1,   1, 3'd2, 0, 8'h84};
        tbl[9]  = '{8'h80, 0, 8'h00, 1, 0,   0, 3'd2, 1, 8'h80};
        tbl[10] = '{8'h00, 0, 8'h00, 0, 0,   0, 3'd2, 1, 8'h80};
        tbl[11] = '{8'h00, 0, 8'h00, 0, 1,   0, 3'd2, 0, 8'h80};
        tbl[12] = '{8'h00, 0, 8'h00, 0, 0,   1, 3'd7, 0, 8'h80};
        tbl[13] = '{8'h00, 1, 8'h80, 0, 0,   0, 3'd7, 0, 8'h80};
        tbl[14] = '{8'h00, 0, 8'h00, 0, 0,   0, 3'd7, 0, 8'h80};
        tbl[15] = '{8'h01, 0, 8'h00, 0, 0,   0, 3'd7, 0, 8'h81};
        tbl[16] = '{8'h01, 0, 8'h00, 0, 0,   1, 3'd0, 0, 8'h81};
        tbl[17] = '{8'h01, 1, 8'h80, 1, 0,   0, 3'd0, 1, 8'h80};
        tbl[18] = '{8'h00, 1, 8'h00, 0, 0,   0, 3'd0, 1, 8'h80};
        tbl[19] = '{8'h00, 0, 8'h00, 0, 1,   0, 3'd0, 0, 8'h80};
        tbl[20] = '{8'h00, 0, 8'h00, 0, 0,   1, 3'd7, 0, 8'h80};
        tbl[21] = '{8'h00, 0, 8'h00, 1, 0,   0, 3'd7, 1, 8'h00};
        tbl[22] = '{8'h00, 0, 8'h00, 0, 1,   0, 3'd7, 0, 8'h00};
        tbl[23] = '{8'h00, 0, 8'h00, 0, 0,   0, 3'd7, 0, 8'h00};

        #3;
        chk("por_fix", outs(1'b0), 13'h0);
        chk("por_rot", outs(1'b1), 13'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++)
            step(tbl[i].req, tbl[i].mwe, tbl[i].md, tbl[i].ack, tbl[i].eoi, 1'b0,
                 tbl[i].irq, tbl[i].vec, tbl[i].busy, tbl[i].pend, $sformatf("tbl%0d", i));

        // Mask write on the granted channel beats a simultaneous ack.
        step(8'h08, 0, 8'h00, 0, 0, 0,  0, 3'd7, 0, 8'h08, "mk_pend");
        step(8'h08, 0, 8'h00, 0, 0, 0,  1, 3'd3, 0, 8'h08, "mk_grant");
        step(8'h08, 1, 8'h08, 1, 0, 0,  0, 3'd3, 0, 8'h08, "mk_abort");
        step(8'h00, 1, 8'h00, 0, 0, 0,  0, 3'd3, 0, 8'h08, "mk_unmask");
        step(8'h00, 0, 8'h00, 0, 0, 0,  1, 3'd3, 0, 8'h08, "mk_regrant");
        step(8'h00, 0, 8'h00, 1, 0, 0,  0, 3'd3, 1, 8'h00, "mk_ack");
        step(8'h00, 0, 8'h00, 0, 1, 0,  0, 3'd3, 0, 8'h00, "mk_eoi");

        // Re-edge on the channel being acked keeps its pend bit.
        step(8'h04, 0, 8'h00, 0, 0, 0,  0, 3'd3, 0, 8'h04, "se_pend");
        step(8'h04, 0, 8'h00, 0, 0, 0,  1, 3'd2, 0, 8'h04, "se_grant");
        step(8'h00, 0, 8'h00, 0, 0, 0,  1, 3'd2, 0, 8'h04, "se_fall");
        step(8'h04, 0, 8'h00, 1, 0, 0,  0, 3'd2, 1, 8'h04, "se_ack_set");
        step(8'h04, 0, 8'h00, 0, 1, 0,  0, 3'd2, 0, 8'h04, "se_eoi");
        step(8'h04, 0, 8'h00, 0, 0, 0,  1, 3'd2, 0, 8'h04, "se_b2b");

        // Rotating priority: after servicing 7, channel 6 outranks 7; after 6, 7 wins again.
        do_reset();
        step(8'h80, 0, 8'h00, 0, 0, 1,  0, 3'd0, 0, 8'h80, "rot_pend7");
        step(8'h00, 0, 8'h00, 0, 0, 1,  1, 3'd7, 0, 8'h80, "rot_grant7");
        step(8'h00, 0, 8'h00, 1, 0, 1,  0, 3'd7, 1, 8'h00, "rot_ack7");
        step(8'h00, 0, 8'h00, 0, 1, 1,  0, 3'd7, 0, 8'h00, "rot_eoi7");
        step(8'hC0, 0, 8'h00, 0, 0, 1,  0, 3'd7, 0, 8'hC0, "rot_pend76");
        step(8'hC0, 0, 8'h00, 0, 0, 1,  1, 3'd6, 0, 8'hC0, "rot_grant6");
        step(8'h00, 0, 8'h00, 1, 0, 1,  0, 3'd6, 1, 8'h80, "rot_ack6");
        step(8'h00, 0, 8'h00, 0, 1, 1,  0, 3'd6, 0, 8'h80, "rot_eoi6");
        step(8'h00, 0, 8'h00, 0, 0, 1,  1, 3'd7, 0, 8'h80, "rot_grant7b");

        // Asynchronous reset during service, then req held high reloads pend on the first edge.
        do_reset();
        step(8'h01, 0, 8'h00, 0, 0, 0,  0, 3'd0, 0, 8'h01, "ar_pend0");
        step(8'h01, 0, 8'h00, 0, 0, 0,  1, 3'd0, 0, 8'h01, "ar_grant0");
        step(8'h01, 0, 8'h00, 1, 0, 0,  0, 3'd0, 1, 8'h00, "ar_ack0");
        step(8'hF1, 0, 8'h00, 0, 0, 0,  0, 3'd0, 1, 8'hF0, "ar_svc_pend");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async_clear", outs(1'b0), 13'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_reload", outs(1'b0), {1'b0, 3'd0, 1'b0, 8'hF1});
        step(8'hF1, 0, 8'h00, 0, 0, 0,  1, 3'd7, 0, 8'hF1, "ar_regrant");

        @(negedge clk);
        req = 8'h00; mask_we = 1'b0; ack = 1'b0; eoi = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
